ccg_resp_capture: RTL and testbench
===================================

Name: ccg_resp_capture

Overview:
- Exhaustive stimulus driver and response compactor wrapped around one combinational benchmark netlist (9 inputs x0..x8, 6 outputs f1..f6).
- Upstream role: sequences all 2^N_IN input vectors into the netlist.
- Downstream role: consumes the outputs and produces a MISR signature, per-output ones-counts, a constant-output mask and a duplicate-output mask.
- These summaries are the labels attached to each netlist variant in the GCN dataset flow.

Parameters:
- N_IN, 9, netlist input count; vector bit i drives xi.
- N_OUT, 6, netlist output count; resp bit j carries f(j+1).
- LAT, 0, netlist pipeline latency in cycles (0..3); 0 means purely combinational.
- MISR_W, 16, signature width; must be >= N_OUT.
- MISR_POLY, 16'h1021, MISR feedback polynomial (taps, x^MISR_W implicit).
- MISR_SEED, 16'hFFFF, signature value loaded at start.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse; begins a sweep when idle.
- abort  in  1  terminates a sweep in progress.
- vec_out  out  N_IN  registered vector to netlist inputs.
- resp_in  in  N_OUT  netlist outputs.
- busy  out  1  high from the cycle after an accepted start until done or abort.
- done  out  1  one-cycle pulse when results are final.
- signature  out  MISR_W  final MISR value.
- ones_cnt  out  N_OUT*(N_IN+1)  packed per-output count of 1 responses; field j = bits [(j+1)*(N_IN+1)-1 : j*(N_IN+1)].
- const_mask  out  N_OUT  bit j set if output j never changed over the sweep.
- eq_mask  out  N_OUT  bit j set if output j equals some output k<j on every vector; bit 0 is always 0.

Behaviour:
- Reset values: vec_out=0, busy=0, done=0, signature=MISR_SEED, ones_cnt=0, const_mask=all ones, eq_mask=all ones except bit 0=0, FSM=IDLE.
- FSM states: IDLE, RUN, DRAIN, DONE.
- IDLE:
  - start=1 → RUN.
  - On the same edge: vec_out=0, signature=MISR_SEED, counters cleared, const_mask and eq_mask reset to their reset values, first-sample flag set.
  - start while busy is ignored.
- RUN:
  - vec_out increments by 1 every cycle.
  - After the cycle in which vec_out=2^N_IN-1, vec_out holds and the FSM goes to DRAIN.
- Sample alignment:
  - A valid shift register of depth LAT marks the cycle in which resp_in corresponds to a vector.
  - Vector v is sampled exactly LAT cycles after the cycle vec_out=v; LAT=0 samples in the same cycle.
  - Exactly 2^N_IN samples are taken per sweep.
- DRAIN: waits until the last sample has been taken (LAT cycles), then → DONE.
- DONE: done=1 for one cycle, busy drops on the same edge, → IDLE. Results hold until the next accepted start.
- Per-sample update:
  - MISR: sig ← (sig<<1) ^ (sig[MISR_W-1] ? MISR_POLY : 0) ^ zero-extend(resp_in).
  - ones_cnt[j] += resp_in[j]. Width N_IN+1 holds 2^N_IN without wrap.
  - const_mask: the first sample is stored; bit j clears on any later sample where resp_in[j] differs from the stored first value.
  - eq_mask bit j (j>0): stays set while some k<j has matched on every sample so far. Implemented as an N_OUT×N_OUT pairwise "still-equal" matrix, cleared per pair on mismatch.
- abort:
  - Valid in RUN or DRAIN; returns to IDLE next edge with busy=0 and no done pulse.
  - Results are left partial and are not valid.
  - abort in IDLE or DONE has no effect.
  - abort and start in the same cycle while IDLE: start wins.
- rst mid-sweep: all state returns to reset values on that edge; no done pulse.
- Sweep length: LAT=0 gives busy high for 2^N_IN+1 cycles; in general busy lasts 2^N_IN+LAT+1 cycles.

Test Plan:
- Identity stub (resp=vec_out[5:0], LAT=0), start pulse → done exactly 514 cycles after start; each ones_cnt field=256; const_mask=6'b000000; eq_mask=6'b000000; signature matches the bench golden MISR model.
- Constant stub (resp=6'b000010), LAT=0 → ones_cnt[1]=512, all other fields 0; const_mask=6'b111111; eq_mask=6'b111100.
- Netlist-shaped stub (f2 tied to 1, f6 wired to f3, others = distinct vector bits), LAT=2 → const_mask bit1=1; eq_mask bit5=1; done 2 cycles later than with LAT=0; first sample corresponds to vector 0.
- abort asserted when vec_out=100 → busy=0 next cycle, no done pulse; a following start gives results identical to a clean run.
- rst asserted mid-sweep at vec_out=300 → all outputs equal reset values next cycle; start pulsed at vec_out=10 (while busy) is ignored, and the sweep still ends after 512 samples.

Source files
------------

// File: rtl/ccg_resp_capture_if.sv
// Purpose : Bundles the sweep control, netlist vector/response bus and the
//           result summaries of ccg_resp_capture into one interface.
// Ports   : start/abort/resp_in flow into the capture block; vec_out, busy,
//           done and the signature/count/mask summaries flow out of it.
//           master = sweep controller + netlist side, slave = capture block.
// Latency : n/a (wires only).
// Backpressure: none; the sweep runs free once started.

interface ccg_resp_capture_if #(
   parameter int N_IN   = 9,
   parameter int N_OUT  = 6,
   parameter int MISR_W = 16
);
   logic                        start;
   logic                        abort;
   logic [N_IN-1:0]             vec_out;
   logic [N_OUT-1:0]            resp_in;
   logic                        busy;
   logic                        done;
   logic [MISR_W-1:0]           signature;
   logic [N_OUT*(N_IN+1)-1:0]   ones_cnt;
   logic [N_OUT-1:0]            const_mask;
   logic [N_OUT-1:0]            eq_mask;

   modport master (
      output start, abort, resp_in,
      input  vec_out, busy, done, signature, ones_cnt, const_mask, eq_mask
   );

   modport slave (
      input  start, abort, resp_in,
      output vec_out, busy, done, signature, ones_cnt, const_mask, eq_mask
   );
endinterface

// File: rtl/ccg_resp_capture.sv
// Purpose : Drives every input vector into a combinational benchmark netlist
//           and compacts its responses into a MISR signature, per-output
//           ones-counts, a constant-output mask and a duplicate-output mask.
// Latency : 2^N_IN + LAT + 1 busy cycles per sweep, done one cycle after busy.
// Backpressure: none; start is ignored while a sweep is in flight, abort
//           cancels it without a done pulse.
//
// Ports:
//   clk, rst          rising-edge clock, synchronous active-high reset
//   bus.start         one-cycle pulse, begins a sweep when idle
//   bus.abort         cancels a sweep in RUN or DRAIN
//   bus.vec_out       registered vector to the netlist inputs (bit i -> xi)
//   bus.resp_in       netlist outputs (bit j <- f(j+1)), LAT cycles behind
//   bus.busy/done     sweep in progress / one-cycle results-final pulse
//   bus.signature     MISR over all samples of the sweep
//   bus.ones_cnt      packed per-output count of 1 responses, N_IN+1 bits each
//   bus.const_mask    output j never changed during the sweep
//   bus.eq_mask       output j equals some lower output on every vector

module ccg_resp_capture #(
   parameter int                N_IN      = 9,
   parameter int                N_OUT     = 6,
   parameter int                LAT       = 0,
   parameter int                MISR_W    = 16,
   parameter logic [MISR_W-1:0] MISR_POLY = 16'h1021,
   parameter logic [MISR_W-1:0] MISR_SEED = 16'hFFFF
) (
   input  logic                clk,
   input  logic                rst,
   ccg_resp_capture_if.slave   bus
);

   localparam int              CW        = N_IN + 1;
   localparam logic [N_IN-1:0] VEC_LAST  = {N_IN{1'b1}};
   // Pipeline stages that are still meaningful for the configured latency.
   localparam logic [3:0]      PIPE_MASK = 4'((1 << LAT) - 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_RUN   = 2'd1,
      S_DRAIN = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t                          state_q;
   logic [N_IN-1:0]                 vec_q;
   logic                            busy_q;
   logic                            done_q;
   logic [MISR_W-1:0]               sig_q,   sig_d;
   logic [N_OUT*CW-1:0]             cnt_q,   cnt_d;
   logic [N_OUT-1:0]                const_q, const_d;
   logic [N_OUT-1:0]                first_val_q;
   logic                            first_q;
   // eqp_q[j][k]: outputs j and k have agreed on every sample so far.
   // Only entries with k < j feed eq_mask.
   logic [N_OUT-1:0][N_OUT-1:0]     eqp_q,   eqp_d;
   // Valid delay line: bit n set means the vector driven n+1 cycles ago
   // was a real sweep vector.
   logic [3:0]                      vld_q;
   logic                            cur_vld;
   logic                            smp_vld;
   logic [N_OUT-1:0]                resp;
   logic [N_OUT-1:0]                eq_mask_c;

   assign resp    = bus.resp_in;
   assign cur_vld = (state_q == S_RUN);

   // resp_in belongs to a sweep vector exactly LAT cycles after that vector
   // was on vec_out.
   generate
      if (LAT == 0) begin : g_lat0
         assign smp_vld = cur_vld;
      end else begin : g_latn
         assign smp_vld = vld_q[LAT-1];
      end
   endgenerate

   // Next summary values assuming the current resp_in is a valid sample.
   always_comb begin
      sig_d = {sig_q[MISR_W-2:0], 1'b0}
            ^ (sig_q[MISR_W-1] ? MISR_POLY : '0)
            ^ MISR_W'(resp);

      cnt_d = cnt_q;
      for (int j = 0; j < N_OUT; j++) begin
         cnt_d[j*CW +: CW] = cnt_q[j*CW +: CW] + CW'(resp[j]);
      end

      // The first sample only establishes the reference value.
      const_d = first_q ? const_q : (const_q & ~(resp ^ first_val_q));

      eqp_d = eqp_q;
      for (int j = 0; j < N_OUT; j++) begin
         for (int k = 0; k < N_OUT; k++) begin
            eqp_d[j][k] = eqp_q[j][k] & ~(resp[j] ^ resp[k]);
         end
      end
   end

   // Output j is a duplicate if any lower-numbered output still tracks it.
   always_comb begin
      eq_mask_c = '0;
      for (int j = 1; j < N_OUT; j++) begin
         for (int k = 0; k < j; k++) begin
            eq_mask_c[j] = eq_mask_c[j] | eqp_q[j][k];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         vec_q       <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         sig_q       <= MISR_SEED;
         cnt_q       <= '0;
         const_q     <= '1;
         first_val_q <= '0;
         first_q     <= 1'b0;
         eqp_q       <= '1;
         vld_q       <= '0;
      end else begin
         vld_q  <= {vld_q[2:0], cur_vld};
         done_q <= 1'b0;

         if (smp_vld) begin
            sig_q   <= sig_d;
            cnt_q   <= cnt_d;
            const_q <= const_d;
            eqp_q   <= eqp_d;
            if (first_q) begin
               first_val_q <= resp;
               first_q     <= 1'b0;
            end
         end

         case (state_q)
            S_IDLE: begin
               // Accepting start overrides any sample bookkeeping above and
               // wipes the previous results.
               if (bus.start) begin
                  state_q <= S_RUN;
                  busy_q  <= 1'b1;
                  vec_q   <= '0;
                  sig_q   <= MISR_SEED;
                  cnt_q   <= '0;
                  const_q <= '1;
                  eqp_q   <= '1;
                  first_q <= 1'b1;
                  vld_q   <= '0;
               end
            end

            S_RUN: begin
               if (bus.abort) begin
                  state_q <= S_IDLE;
                  busy_q  <= 1'b0;
                  vld_q   <= '0;
               end else if (vec_q == VEC_LAST) begin
                  state_q <= S_DRAIN;
               end else begin
                  vec_q <= vec_q + 1'b1;
               end
            end

            S_DRAIN: begin
               if (bus.abort) begin
                  state_q <= S_IDLE;
                  busy_q  <= 1'b0;
                  vld_q   <= '0;
               end else if ((vld_q & PIPE_MASK) == 4'd0) begin
                  // Last in-flight response has been absorbed.
                  state_q <= S_DONE;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
               end
            end

            S_DONE: begin
               state_q <= S_IDLE;
            end

            default: begin
               state_q <= S_IDLE;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign bus.vec_out    = vec_q;
   assign bus.busy       = busy_q;
   assign bus.done       = done_q;
   assign bus.signature  = sig_q;
   assign bus.ones_cnt   = cnt_q;
   assign bus.const_mask = const_q;
   assign bus.eq_mask    = eq_mask_c;

endmodule

// File: tb/tb_ccg_resp_capture.sv
// Purpose : Self-checking bench for ccg_resp_capture; two instances (LAT=0
//           and LAT=2) sweep the same stub netlists side by side.
// Latency : n/a.
// Backpressure: n/a.

module tb_ccg_resp_capture;

   typedef struct packed {
      logic [15:0] sig;
      logic [59:0] cnt;
      logic [5:0]  cm;
      logic [5:0]  em;
   } res_t;

   localparam res_t RES0 = '{sig: 16'hFFFF, cnt: 60'd0, cm: 6'h3F, em: 6'h3E};

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic start = 1'b0;
   logic abort = 1'b0;
   int   mode = 0;
   bit   chk_en = 1'b0;
   int   n_chk = 0;
   int   n_fail = 0;

   logic [5:0] tt [512];

   always #5 clk = ~clk;

   ccg_resp_capture_if #(.N_IN(9), .N_OUT(6), .MISR_W(16)) if0 ();
   ccg_resp_capture_if #(.N_IN(9), .N_OUT(6), .MISR_W(16)) if2 ();

   ccg_resp_capture #(.N_IN(9), .N_OUT(6), .LAT(0), .MISR_W(16),
                      .MISR_POLY(16'h1021), .MISR_SEED(16'hFFFF))
   dut0 (.clk(clk), .rst(rst), .bus(if0.slave));

   ccg_resp_capture #(.N_IN(9), .N_OUT(6), .LAT(2), .MISR_W(16),
                      .MISR_POLY(16'h1021), .MISR_SEED(16'hFFFF))
   dut2 (.clk(clk), .rst(rst), .bus(if2.slave));

   logic [8:0]  a_vec  [2];
   logic        a_busy [2];
   logic        a_done [2];
   logic [15:0] a_sig  [2];
   logic [59:0] a_cnt  [2];
   logic [5:0]  a_cm   [2];
   logic [5:0]  a_em   [2];

   assign a_vec[0] = if0.vec_out;    assign a_vec[1] = if2.vec_out;
   assign a_busy[0] = if0.busy;      assign a_busy[1] = if2.busy;
   assign a_done[0] = if0.done;      assign a_done[1] = if2.done;
   assign a_sig[0] = if0.signature;  assign a_sig[1] = if2.signature;
   assign a_cnt[0] = if0.ones_cnt;   assign a_cnt[1] = if2.ones_cnt;
   assign a_cm[0] = if0.const_mask;  assign a_cm[1] = if2.const_mask;
   assign a_em[0] = if0.eq_mask;     assign a_em[1] = if2.eq_mask;

   assign if0.start = start;  assign if0.abort = abort;
   assign if2.start = start;  assign if2.abort = abort;

   // Stub netlists: 0 identity, 1 constant, 2 netlist-shaped, 3 random table.
   function automatic logic [5:0] stub(input int m, input logic [8:0] v);
      case (m)
         0:       return v[5:0];
         1:       return 6'b000010;
         2:       return {v[1], v[3], v[2], v[1], 1'b1, v[0]};
         default: return tt[v];
      endcase
   endfunction

   // The LAT=2 instance sees its netlist through a two-stage pipeline.
   logic [8:0] d1 = '0;
   logic [8:0] d2 = '0;
   always @(posedge clk) begin
      d1 <= a_vec[1];
      d2 <= d1;
   end

   assign if0.resp_in = stub(mode, a_vec[0]);
   assign if2.resp_in = stub(mode, d2);

   function automatic int latof(input int d);
      return (d == 0) ? 0 : 2;
   endfunction

   // Expected sweep results, derived column-wise over the whole truth table.
   function automatic res_t model_res(input int m);
      res_t         r;
      logic [511:0] col [6];
      logic [5:0]   v;
      logic         fb;
      r.sig = 16'hFFFF;
      for (int i = 0; i < 512; i++) begin
         v  = stub(m, 9'(i));
         fb = r.sig[15];
         r.sig = r.sig << 1;
         if (fb) r.sig = r.sig ^ 16'h1021;
         r.sig = r.sig ^ {10'd0, v};
         for (int j = 0; j < 6; j++) col[j][i] = v[j];
      end
      r.cnt = '0;
      r.cm  = '0;
      r.em  = '0;
      for (int j = 0; j < 6; j++) begin
         r.cnt[j*10 +: 10] = 10'($countones(col[j]));
         r.cm[j] = (col[j] == '0) || (col[j] == '1);
         for (int k = 0; k < j; k++)
            if (col[k] == col[j]) r.em[j] = 1'b1;
      end
      return r;
   endfunction

   task automatic gen_tt();
      logic [511:0] col [6];
      int           sel;
      int           k;
      logic         b;
      for (int j = 0; j < 6; j++) begin
         sel = $urandom_range(0, 4);
         if (j == 0 && (sel == 2 || sel == 3)) sel = 0;
         for (int w = 0; w < 16; w++) col[j][w*32 +: 32] = $urandom;
         b = 1'($urandom_range(0, 1));
         k = (j > 0) ? $urandom_range(0, j - 1) : 0;
         case (sel)
            1: col[j] = {512{b}};
            2: col[j] = col[k];
            3: begin col[j] = col[k]; col[j][$urandom_range(0, 511)] ^= 1'b1; end
            4: begin col[j] = {512{b}}; col[j][$urandom_range(0, 511)] ^= 1'b1; end
            default: ;
         endcase
      end
      for (int i = 0; i < 512; i++)
         for (int j = 0; j < 6; j++) tt[i][j] = col[j][i];
   endtask

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Cycle model per instance: p = cycles since the accepting edge (-1 idle),
   // rstate 0 = reset results, 1 = this sweep's finals, 2 = undefined.
   int         p      [2] = '{-1, -1};
   logic [8:0] mvec   [2] = '{9'd0, 9'd0};
   int         rstate [2] = '{0, 0};
   res_t       exp_r  [2];

   always @(posedge clk) begin
      for (int d = 0; d < 2; d++) begin
         int         np;
         logic [8:0] nv;
         int         nr;
         res_t       ne;
         np = p[d]; nv = mvec[d]; nr = rstate[d]; ne = exp_r[d];
         if (rst) begin
            np = -1; nv = '0; nr = 0;
         end else if (np < 0) begin
            if (start) begin
               np = 0; nv = '0; nr = 1; ne = model_res(mode);
            end
         end else if (abort && np <= 512 + latof(d)) begin
            np = -1; nr = 2;
         end else if (np == 513 + latof(d)) begin
            np = -1;
         end else begin
            np = np + 1;
            if (np <= 511) nv = 9'(np);
         end
         p[d] <= np; mvec[d] <= nv; rstate[d] <= nr; exp_r[d] <= ne;
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         for (int d = 0; d < 2; d++) begin
            int   L;
            bit   do_res;
            res_t er;
            L = latof(d);
            chk($sformatf("busy%0d", d), 64'(a_busy[d]), 64'(p[d] >= 0 && p[d] <= 512 + L));
            chk($sformatf("done%0d", d), 64'(a_done[d]), 64'(p[d] == 513 + L));
            chk($sformatf("vec%0d", d), 64'(a_vec[d]), 64'(mvec[d]));
            do_res = 1'b1;
            er = RES0;
            if (p[d] == 0 || (p[d] < 0 && rstate[d] == 0)) er = RES0;
            else if (p[d] == 513 + L || (p[d] < 0 && rstate[d] == 1)) er = exp_r[d];
            else do_res = 1'b0;
            if (do_res) begin
               chk($sformatf("sig%0d", d), 64'(a_sig[d]), 64'(er.sig));
               chk($sformatf("ones%0d", d), 64'(a_cnt[d]), 64'(er.cnt));
               chk($sformatf("const%0d", d), 64'(a_cm[d]), 64'(er.cm));
               chk($sformatf("eq%0d", d), 64'(a_em[d]), 64'(er.em));
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Start pulse (optionally with abort, or a second start at cycle ign),
   // then wait for both done pulses; n0/n2 = cycles from start to done.
   task automatic sweep(input bit ab, input int ign, output int n0, output int n2);
      n0 = 0; n2 = 0;
      start = 1'b1; abort = ab;
      for (int c = 1; c <= 1200 && (n0 == 0 || n2 == 0); c++) begin
         tick();
         if (c == 1) begin start = 1'b0; abort = 1'b0; end
         if (ign != 0 && c == ign) begin
            chk("vec_at_extra_start", 64'(a_vec[0]), 64'(ign - 1));
            start = 1'b1;
         end
         if (ign != 0 && c == ign + 1) start = 1'b0;
         if (a_done[0] && n0 == 0) n0 = c;
         if (a_done[1] && n2 == 0) n2 = c;
      end
      chk("sweep_completed", 64'(n0 != 0 && n2 != 0), 64'd1);
      tick(); tick();
   endtask

   task automatic wait_vec(input logic [8:0] v);
      int c;
      c = 0;
      while (a_vec[0] != v && c < 2000) begin tick(); c++; end
      chk("wait_vec", 64'(a_vec[0]), 64'(v));
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int n0, n2, c;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      chk_en = 1'b1;
      tick();

      // Identity stub.
      mode = 0;
      sweep(1'b0, 0, n0, n2);
      chk("latency_lat0", 64'(n0), 64'd514);
      chk("latency_lat2", 64'(n2), 64'd516);
      for (int j = 0; j < 6; j++)
         chk($sformatf("ident_ones%0d", j), 64'(a_cnt[0][j*10 +: 10]), 64'd256);
      chk("ident_const", 64'(a_cm[0]), 64'h00);
      chk("ident_eq", 64'(a_em[0]), 64'h00);

      // Constant stub.
      mode = 1;
      sweep(1'b0, 0, n0, n2);
      for (int j = 0; j < 6; j++)
         chk($sformatf("const_ones%0d", j), 64'(a_cnt[0][j*10 +: 10]), (j == 1) ? 64'd512 : 64'd0);
      chk("const_const", 64'(a_cm[0]), 64'h3F);
      chk("const_eq", 64'(a_em[0]), 64'h3C);

      // Netlist-shaped stub.
      mode = 2;
      sweep(1'b0, 0, n0, n2);
      chk("shaped_lat_delta", 64'(n2 - n0), 64'd2);
      chk("shaped_const2", 64'(a_cm[1]), 64'h02);
      chk("shaped_eq2", 64'(a_em[1]), 64'h20);
      chk("shaped_ones1", 64'(a_cnt[1][10 +: 10]), 64'd512);

      // Random truth tables; one start arrives together with abort.
      for (int s = 0; s < 4; s++) begin
         mode = 3;
         gen_tt();
         sweep(s == 1, 0, n0, n2);
      end

      // Abort at vector 100, then a clean rerun of the same table.
      gen_tt();
      start = 1'b1; tick(); start = 1'b0;
      wait_vec(9'd100);
      abort = 1'b1; tick(); abort = 1'b0;
      chk("abort_busy0", 64'(a_busy[0]), 64'd0);
      chk("abort_busy2", 64'(a_busy[1]), 64'd0);
      repeat (20) tick();
      sweep(1'b0, 0, n0, n2);

      // Second start while busy (at vector 10) is ignored.
      mode = 2;
      sweep(1'b0, 11, n0, n2);
      chk("ignored_start_lat0", 64'(n0), 64'd514);
      chk("ignored_start_lat2", 64'(n2), 64'd516);

      // Reset mid-sweep at vector 300.
      mode = 3;
      gen_tt();
      start = 1'b1; tick(); start = 1'b0;
      wait_vec(9'd300);
      rst = 1'b1; tick(); rst = 1'b0;
      chk("rst_sig", 64'(a_sig[0]), 64'hFFFF);
      chk("rst_vec", 64'(a_vec[0]), 64'd0);
      chk("rst_eq", 64'(a_em[1]), 64'h3E);
      repeat (5) tick();
      sweep(1'b0, 0, n0, n2);

      // Abort while the LAT=0 instance shows done: ignored there, but the
      // LAT=2 instance is still draining and gets cancelled.
      start = 1'b1; tick(); start = 1'b0;
      c = 0;
      while (!a_done[0] && c < 1200) begin tick(); c++; end
      chk("done_seen", 64'(a_done[0]), 64'd1);
      abort = 1'b1; tick(); abort = 1'b0;
      repeat (10) tick();

      mode = 3;
      gen_tt();
      sweep(1'b0, 0, n0, n2);

      chk_en = 1'b0;
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
